// File: rtl/pcpu_pkg.sv
// Shared definitions for the pipelined CPU: fetch state encoding and
// fetch-path constants.
package pcpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] PC_INC     = 32'd4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/if_hold_buffer.sv
// One-entry {npc, instr} buffer that parks a fetched word while the
// pipeline is stalled.
module if_hold_buffer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_npc,
  input  logic [31:0]       load_instr,
  output logic              valid,
  output logic [ADDR_W-1:0] npc,
  output logic [31:0]       instr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  // NOTE: only the valid flag is reset; the payload is qualified by valid,
  // so its registers carry no reset and can map to plain flops.
  always_ff @(posedge clk) begin
    if (load) begin
      npc   <= load_npc;
      instr <= load_instr;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the variable-latency
// instruction memory and hands {NPC, instruction} to IF/ID.
module if_fetch_unit
  import pcpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_write,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] npc_if_o,
  output logic [31:0]       instr_if_o,
  output logic              if_valid_o
);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] redirect_target;
  logic [ADDR_W-1:0] drop_addr;
  logic              drop_load;
  logic              hold_load, hold_clear, hold_valid;
  logic [ADDR_W-1:0] hold_npc;
  logic [31:0]       hold_instr;

  assign pc_inc          = pc + ADDR_W'(PC_INC);
  assign redirect_target = redirect_pc & ADDR_W'(ALIGN_MASK);

  // A request abandoned by a redirect keeps its address on the bus until
  // its ack, so the PC can move on independently.
  assign imem_addr = (state == DROP) ? drop_addr : pc;

  if_hold_buffer #(.ADDR_W(ADDR_W)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (hold_load),
    .clear     (hold_clear),
    .load_npc  (pc_inc),
    .load_instr(imem_rdata),
    .valid     (hold_valid),
    .npc       (hold_npc),
    .instr     (hold_instr)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      drop_addr <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (drop_load) drop_addr <= pc;
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a variable unassigned, which would infer a latch.
    state_next = state;
    pc_next    = pc;
    imem_req   = 1'b0;
    if_valid_o = 1'b0;
    npc_if_o   = '0;
    instr_if_o = NOP_INSTR;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    drop_load  = 1'b0;

    case (state)
      IDLE: begin
        state_next = REQ;
        if (redirect_valid) pc_next = redirect_target;
      end

      REQ: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          pc_next = redirect_target;
          if (!imem_ack) begin
            state_next = DROP;
            drop_load  = 1'b1;
          end
        end else if (imem_ack) begin
          pc_next = pc_inc;
          if (pc_write) begin
            if_valid_o = 1'b1;
            npc_if_o   = pc_inc;
            instr_if_o = imem_rdata;
          end else begin
            hold_load  = 1'b1;
            state_next = HOLD;
          end
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          pc_next    = redirect_target;
          hold_clear = 1'b1;
          state_next = REQ;
        end else if (pc_write) begin
          if (hold_valid) begin
            if_valid_o = 1'b1;
            npc_if_o   = hold_npc;
            instr_if_o = hold_instr;
          end
          hold_clear = 1'b1;
          state_next = REQ;
        end
      end

      DROP: begin
        imem_req = 1'b1;
        if (redirect_valid) pc_next = redirect_target;
        if (imem_ack) state_next = REQ;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: cycle-by-cycle directed stimulus
// with a scoreboard of expected IF/ID hand-offs.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] npc_if_o;
  logic [31:0] instr_if_o;
  logic        if_valid_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] npc;
    logic [31:0] instr;
  } handoff_t;

  handoff_t sb[$];

  localparam logic [31:0] W1 = 32'h2001_0005;
  localparam logic [31:0] W2 = 32'hAC02_0000;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  if_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_write      (pc_write),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .npc_if_o      (npc_if_o),
    .instr_if_o    (instr_if_o),
    .if_valid_o    (if_valid_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs just after a negedge, sample 1 ns later,
  // then advance to the next negedge.
  task automatic cycle(input string tag, input logic ack, input logic pw,
                       input logic redir, input logic [31:0] rpc,
                       input logic [31:0] rdata, input logic exp_req,
                       input logic [31:0] exp_addr, input logic exp_valid,
                       input logic [31:0] exp_npc, input logic [31:0] exp_instr);
    handoff_t e;
    imem_ack       = ack;
    pc_write       = pw;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rdata     = rdata;
    if (exp_valid) sb.push_back('{npc: exp_npc, instr: exp_instr});
    #1;
    check({tag, ".req"}, 32'(imem_req), 32'(exp_req));
    if (exp_req) check({tag, ".addr"}, imem_addr, exp_addr);
    check({tag, ".valid"}, 32'(if_valid_o), 32'(exp_valid));
    if (if_valid_o && sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, ".npc"}, npc_if_o, e.npc);
      check({tag, ".instr"}, instr_if_o, e.instr);
    end else if (!if_valid_o) begin
      check({tag, ".npc0"}, npc_if_o, 32'h0);
      check({tag, ".instr0"}, instr_if_o, 32'h0);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    pc_write = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    #1;
    check("rst.req", 32'(imem_req), 32'h0);
    check("rst.addr", imem_addr, 32'h0);
    check("rst.valid", 32'(if_valid_o), 32'h0);
    check("rst.npc", npc_if_o, 32'h0);
    check("rst.instr", instr_if_o, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic fetch stream, ack one cycle after each request
    //     tag        ack  pw  rd  rpc      rdata  req addr          v  npc            instr
    cycle("idle",     0,   1,  0,  32'h0,   W1,    0,  32'h0,        0, 32'h0,        32'h0);
    cycle("t1.w0",    0,   1,  0,  32'h0,   W1,    1,  32'h0,        0, 32'h0,        32'h0);
    cycle("t1.a0",    1,   1,  0,  32'h0,   W1,    1,  32'h0,        1, 32'h4,        W1);
    cycle("t1.w4",    0,   1,  0,  32'h0,   W1,    1,  32'h4,        0, 32'h0,        32'h0);
    cycle("t1.a4",    1,   1,  0,  32'h0,   W1,    1,  32'h4,        1, 32'h8,        W1);
    cycle("t1.w8",    0,   1,  0,  32'h0,   W1,    1,  32'h8,        0, 32'h0,        32'h0);
    cycle("t1.a8",    1,   1,  0,  32'h0,   W1,    1,  32'h8,        1, 32'hC,        W1);

    // Stall: ack with pc_write=0 parks the word, released three cycles later
    cycle("t2.wc",    0,   1,  0,  32'h0,   W2,    1,  32'hC,        0, 32'h0,        32'h0);
    cycle("t2.ac",    1,   0,  0,  32'h0,   W2,    1,  32'hC,        0, 32'h0,        32'h0);
    cycle("t2.h1",    0,   0,  0,  32'h0,   JUNK,  0,  32'h0,        0, 32'h0,        32'h0);
    cycle("t2.h2",    0,   0,  0,  32'h0,   JUNK,  0,  32'h0,        0, 32'h0,        32'h0);
    cycle("t2.rel",   0,   1,  0,  32'h0,   JUNK,  0,  32'h0,        1, 32'h10,       W2);

    // Redirect while request at 0x10 is pending; stale ack two cycles later
    cycle("t3.r",     0,   1,  1,  32'h103, JUNK,  1,  32'h10,       0, 32'h0,        32'h0);
    cycle("t3.d1",    0,   1,  0,  32'h0,   JUNK,  1,  32'h10,       0, 32'h0,        32'h0);
    cycle("t3.dack",  1,   1,  0,  32'h0,   JUNK,  1,  32'h10,       0, 32'h0,        32'h0);

    // Redirect in the same cycle as an ack
    cycle("t4.w100",  0,   1,  0,  32'h0,   JUNK,  1,  32'h100,      0, 32'h0,        32'h0);
    cycle("t4.ra",    1,   1,  1,  32'h200, JUNK,  1,  32'h100,      0, 32'h0,        32'h0);
    cycle("t4.w200",  0,   1,  0,  32'h0,   W1,    1,  32'h200,      0, 32'h0,        32'h0);
    cycle("t4.a200",  1,   1,  0,  32'h0,   W1,    1,  32'h200,      1, 32'h204,      W1);

    // Redirect while holding: held word must never appear
    cycle("t5.w204",  0,   0,  0,  32'h0,   JUNK,  1,  32'h204,      0, 32'h0,        32'h0);
    cycle("t5.a204",  1,   0,  0,  32'h0,   JUNK,  1,  32'h204,      0, 32'h0,        32'h0);
    cycle("t5.hr",    0,   1,  1,  32'h300, JUNK,  0,  32'h0,        0, 32'h0,        32'h0);

    // Redirect again while dropping: latest target wins
    cycle("t5.r400",  0,   1,  1,  32'h400, JUNK,  1,  32'h300,      0, 32'h0,        32'h0);
    cycle("t5.r500",  0,   1,  1,  32'h501, JUNK,  1,  32'h300,      0, 32'h0,        32'h0);
    cycle("t5.dack",  1,   1,  0,  32'h0,   JUNK,  1,  32'h300,      0, 32'h0,        32'h0);
    cycle("t5.w500",  0,   1,  0,  32'h0,   JUNK,  1,  32'h500,      0, 32'h0,        32'h0);

    // Reset during the outstanding request at 0x500, late ack during reset
    #1;
    rst = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = JUNK;
    #1;
    check("t6.req", 32'(imem_req), 32'h0);
    check("t6.addr", imem_addr, 32'h0);
    check("t6.valid", 32'(if_valid_o), 32'h0);
    check("t6.npc", npc_if_o, 32'h0);
    check("t6.instr", instr_if_o, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle("t6.idle",  1,   1,  0,  32'h0,   JUNK,  0,  32'h0,        0, 32'h0,        32'h0);
    cycle("t6.w0",    0,   1,  0,  32'h0,   W2,    1,  32'h0,        0, 32'h0,        32'h0);
    cycle("t6.a0",    1,   1,  0,  32'h0,   W2,    1,  32'h0,        1, 32'h4,        W2);

    // PC wrap at the top of the address space
    cycle("t7.ra",    1,   1,  1,  32'hFFFF_FFFF, JUNK, 1, 32'h4,    0, 32'h0,        32'h0);
    cycle("t7.wtop",  0,   1,  0,  32'h0,   W1,    1,  32'hFFFF_FFFC, 0, 32'h0,       32'h0);
    cycle("t7.atop",  1,   1,  0,  32'h0,   W1,    1,  32'hFFFF_FFFC, 1, 32'h0,       W1);
    cycle("t7.w0",    0,   1,  0,  32'h0,   W1,    1,  32'h0,        0, 32'h0,        32'h0);

    check("sb.drain", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
